sat_addsub_pipe: RTL

SAT_ADDSUB_PIPE -- requirements
Module: sat_addsub_pipe

---
 rtl/sat_addsub_pipe.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sat_addsub_pipe.sv
// sat_addsub_pipe: two-stage saturating add/subtract/accumulate pipeline.
// Stage 1 registers the op and its WIDTH+1-bit raw result. Stage 2 registers
// the saturated result and its clamp flags. A single global stall holds both
// stages while a result is waiting and out_ready is low.
// Optional feature: define SAT_EVENT_CNT_EN to build the saturation event
// counter behind sat_cnt. Without it, sat_cnt is tied to zero.
module sat_addsub_pipe #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             ovf,
    output logic             unf,
    output logic [15:0]      sat_cnt
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    // Clamp a WIDTH+1-bit raw value to WIDTH bits; returns {z, ovf, unf}.
    // In unsigned mode the top raw bit is a carry for add/accumulate and a
    // borrow for subtract, so the op decides which flag it raises.
    function automatic logic [WIDTH+1:0] saturate(input logic [WIDTH:0] raw,
                                                  input logic is_sub);
        logic             o;
        logic             u;
        logic [WIDTH-1:0] r;
        if (SIGNED) begin
            o = ~raw[WIDTH] & raw[WIDTH-1];
            u = raw[WIDTH] & ~raw[WIDTH-1];
        end else begin
            o = raw[WIDTH] & ~is_sub;
            u = raw[WIDTH] & is_sub;
        end
        if (o) begin
            r = '1;
            if (SIGNED) r[WIDTH-1] = 1'b0;
        end else if (u) begin
            r = '0;
            if (SIGNED) r[WIDTH-1] = 1'b1;
        end else begin
            r = raw[WIDTH-1:0];
        end
        return {r, o, u};
    endfunction

    logic             advance;
    logic             accept;
    op_e              op_in;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   acc_ext;
    logic [WIDTH:0]   raw;
    logic [WIDTH+1:0] acc_sat;
    logic [WIDTH+1:0] s2_sat;

    logic             s1_valid_q, s1_valid_d;
    op_e              s1_op_q, s1_op_d;
    logic [WIDTH:0]   s1_raw_q, s1_raw_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    assign advance   = ~s2_valid_q | out_ready;
    assign in_ready  = advance;
    assign accept    = in_valid & advance;
    assign out_valid = s2_valid_q;
    assign z         = z_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

    // Extend operands and form the raw result for the op being presented.
    always_comb begin
        op_in   = op_e'(op);
        a_ext   = {SIGNED & a[WIDTH-1], a};
        b_ext   = {SIGNED & b[WIDTH-1], b};
        acc_ext = {SIGNED & acc_q[WIDTH-1], acc_q};
        case (op_in)
            OP_ADD:  raw = a_ext + b_ext;
            OP_SUB:  raw = a_ext - b_ext;
            OP_ACC:  raw = acc_ext + a_ext;
            default: raw = '0;
        endcase
        acc_sat = saturate(raw, 1'b0);
        s2_sat  = saturate(s1_raw_q, s1_op_q == OP_SUB);
    end

    // Next-state for both stages and the accumulator. The accumulator is
    // written at acceptance (not at stage 2) so a following accumulate
    // presented on the very next cycle already sees the updated value.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_raw_d   = s1_raw_q;
        s2_valid_d = s2_valid_q;
        z_d        = z_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        acc_d      = acc_q;
        if (advance) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_op_d  = op_in;
                s1_raw_d = raw;
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                z_d   = s2_sat[WIDTH+1:2];
                ovf_d = s2_sat[1];
                unf_d = s2_sat[0];
            end
        end
        if (accept && op_in == OP_ACC) acc_d = acc_sat[WIDTH+1:2];
        if (accept && op_in == OP_CLR) acc_d = '0;
    end

    // Pipeline and accumulator registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_ADD;
            s1_raw_q   <= '0;
            s2_valid_q <= 1'b0;
            z_q        <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_raw_q   <= s1_raw_d;
            s2_valid_q <= s2_valid_d;
            z_q        <= z_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            acc_q      <= acc_d;
        end
    end

`ifdef SAT_EVENT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    // Count delivered clamped results, sticking at all-ones.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (s2_valid_q && out_ready && (ovf_q || unf_q) && sat_cnt_q != '1)
            sat_cnt_d = sat_cnt_q + 16'd1;
    end

    // Saturation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sat_cnt_q <= '0;
        else     sat_cnt_q <= sat_cnt_d;
    end

    assign sat_cnt = sat_cnt_q;
`else
    assign sat_cnt = '0;
`endif

endmodule
